// File: rtl/rf_dma_ctrl_if.sv
// rtl/rf_dma_ctrl_if.sv - command, AXI read and output stream bundle for rf_dma_ctrl
interface rf_dma_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic              m_arvalid;
  logic              m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  cmd_addr, cmd_valid,
    output cmd_ready,
    output m_araddr, m_arlen, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rresp, m_rlast, m_rvalid,
    output m_rready,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    output cmd_addr, cmd_valid,
    input  cmd_ready,
    input  m_araddr, m_arlen, m_arvalid,
    output m_arready,
    output m_rdata, m_rresp, m_rlast, m_rvalid,
    input  m_rready,
    input  out_data, out_valid,
    output out_ready
  );
endinterface

// File: rtl/rf_dma_ctrl.sv
// rtl/rf_dma_ctrl.sv - queued AXI4 read DMA splitting commands into fixed INCR bursts
module rf_dma_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int BURST_LEN  = 16,
  parameter int XFER_BEATS = 64,
  parameter int CMD_DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  rf_dma_ctrl_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int NBURST = XFER_BEATS / BURST_LEN;
  localparam int PW     = $clog2(CMD_DEPTH);
  localparam int BCW    = $clog2(NBURST + 1);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] fifo_mem [CMD_DEPTH];
  logic [PW:0]       wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full, push, pop;
  logic [ADDR_W-1:0] addr_q;
  logic [BCW-1:0]    burst_cnt;
  logic [7:0]        beat_cnt;
  logic              err_q, beat, last_beat;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push       = bus.cmd_valid && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign beat       = (state_q == S_DATA) && bus.m_rvalid && bus.out_ready;
  assign last_beat  = (beat_cnt == 8'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= bus.cmd_addr;
  end

  // A slot freed by pop only shows up in cmd_ready on the following cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!fifo_empty) state_d = S_ADDR;
      S_ADDR: if (bus.m_arready) state_d = S_DATA;
      S_DATA: if (beat && last_beat) state_d = (burst_cnt == BCW'(1)) ? S_DONE : S_ADDR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      burst_cnt <= '0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (pop) begin
        addr_q    <= fifo_mem[rd_ptr[PW-1:0]];
        burst_cnt <= BCW'(NBURST);
      end
      if ((state_q == S_ADDR) && bus.m_arready) begin
        addr_q   <= addr_q + BURST_BYTES;
        beat_cnt <= '0;
      end
      // Protocol errors are recorded but the burst still runs to its beat count
      if (beat) begin
        beat_cnt <= beat_cnt + 8'd1;
        if (last_beat) burst_cnt <= burst_cnt - BCW'(1);
        if ((bus.m_rresp != 2'b00) || (bus.m_rlast != last_beat)) err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.m_arvalid = 1'b0;
    bus.m_rready  = 1'b0;
    bus.out_valid = 1'b0;
    done          = 1'b0;
    case (state_q)
      S_ADDR: bus.m_arvalid = 1'b1;
      S_DATA: begin
        bus.m_rready  = bus.out_ready;
        bus.out_valid = bus.m_rvalid;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.m_araddr  = addr_q;
  assign bus.m_arlen   = 8'(BURST_LEN - 1);
  assign bus.out_data  = bus.m_rdata;
  assign busy          = !fifo_empty || (state_q != S_IDLE);
  assign err           = err_q;
endmodule
